// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_MEM_WAIT
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding comparator for one ALU operand: picks M, then W, then the register file.
module fwd_sel
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rs_e_i,
    input  logic [REG_W-1:0] rd_m_i,
    input  logic [REG_W-1:0] rd_w_i,
    input  logic             regwrite_m_i,
    input  logic             regwrite_w_i,
    output logic [1:0]       sel_o
);

    // M stage wins over W since it holds the younger result.
    always_comb begin
        sel_o = FWD_RF;
        if (regwrite_m_i && (rd_m_i != '0) && (rs_e_i == rd_m_i)) begin
            sel_o = FWD_MEM;
        end else if (regwrite_w_i && (rd_w_i != '0) && (rs_e_i == rd_w_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage RV32 pipeline.
// Optional macro HAZ_PERF_CNT_EN adds saturating performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rs2_d,
    input  logic [REG_W-1:0] rs1_e,
    input  logic [REG_W-1:0] rs2_e,
    input  logic [REG_W-1:0] rd_e,
    input  logic [REG_W-1:0] rd_m,
    input  logic [REG_W-1:0] rd_w,
    input  logic             regwrite_m,
    input  logic             regwrite_w,
    input  logic             resultsrc_e0,
    input  logic             pcsrc_e,
    input  logic             memaccess_m,
    input  logic             dmem_ready,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             mem_timeout
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]      perf_lw_stall_cnt,
    output logic [31:0]      perf_flush_cnt,
    output logic [31:0]      perf_mem_wait_cnt
`endif
);

    localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [3:0] init_cnt_q, init_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_timeout_q, mem_timeout_d;

    logic       active;
    logic       mem_pending;
    logic       timeout_hit;
    logic       mem_stall;
    logic       lw_stall;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    fwd_sel u_fwd_a (
        .rs_e_i       (rs1_e),
        .rd_m_i       (rd_m),
        .rd_w_i       (rd_w),
        .regwrite_m_i (regwrite_m),
        .regwrite_w_i (regwrite_w),
        .sel_o        (fwd_a_raw)
    );

    fwd_sel u_fwd_b (
        .rs_e_i       (rs2_e),
        .rd_m_i       (rd_m),
        .rd_w_i       (rd_w),
        .regwrite_m_i (regwrite_m),
        .regwrite_w_i (regwrite_w),
        .sel_o        (fwd_b_raw)
    );

    // Hazard terms; wait_cnt_q counts cycles already spent frozen on this access.
    always_comb begin
        active      = (state_q != ST_INIT);
        mem_pending = memaccess_m && !dmem_ready;
        timeout_hit = (state_q == ST_MEM_WAIT) && mem_pending && (wait_cnt_q == WAIT_LAST);
        mem_stall   = active && mem_pending && !timeout_hit;
        lw_stall    = resultsrc_e0 && (rd_e != '0) && ((rs1_d == rd_e) || (rs2_d == rd_e));
    end

    // Prioritised stall/flush/forward outputs; INIT forces a bubble through every stage.
    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_w     = 1'b0;
        forward_a_e = FWD_RF;
        forward_b_e = FWD_RF;
        if (!active) begin
            stall_f = 1'b1;
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
        end else begin
            forward_a_e = fwd_a_raw;
            forward_b_e = fwd_b_raw;
            if (mem_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (pcsrc_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (lw_stall) begin
                // One bubble suffices: the load reaches M on the next edge.
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
        mem_timeout = mem_timeout_q;
    end

    // Next-state for the sequencing FSM and its counters.
    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q | timeout_hit;
        unique case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 4'd1;
                if (init_cnt_q == INIT_LAST) begin
                    state_d    = ST_RUN;
                    init_cnt_d = '0;
                    wait_cnt_d = '0;
                end
            end
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_stall) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = '0;
                wait_cnt_d = '0;
            end
        endcase
    end

    // State registers; reset returns straight to INIT with counters cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_INIT;
            init_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic        lw_evt, flush_evt;
    logic [31:0] perf_lw_q, perf_lw_d;
    logic [31:0] perf_fl_q, perf_fl_d;
    logic [31:0] perf_mw_q, perf_mw_d;

    // Saturating event counters; events mirror the priority chain above.
    always_comb begin
        lw_evt    = active && !mem_stall && !pcsrc_e && lw_stall;
        flush_evt = active && !mem_stall && pcsrc_e;
        perf_lw_d = perf_lw_q;
        perf_fl_d = perf_fl_q;
        perf_mw_d = perf_mw_q;
        if (lw_evt && (perf_lw_q != '1)) perf_lw_d = perf_lw_q + 32'd1;
        if (flush_evt && (perf_fl_q != '1)) perf_fl_d = perf_fl_q + 32'd1;
        if (mem_stall && (perf_mw_q != '1)) perf_mw_d = perf_mw_q + 32'd1;
        perf_lw_stall_cnt = perf_lw_q;
        perf_flush_cnt    = perf_fl_q;
        perf_mem_wait_cnt = perf_mw_q;
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lw_q <= '0;
            perf_fl_q <= '0;
            perf_mw_q <= '0;
        end else begin
            perf_lw_q <= perf_lw_d;
            perf_fl_q <= perf_fl_d;
            perf_mw_q <= perf_mw_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized self-checking bench for pipe_hazard_ctrl with a cycle-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned INIT_CYCLES = 2;
    localparam int unsigned MEM_TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       regwrite_m, regwrite_w, resultsrc_e0, pcsrc_e, memaccess_m, dmem_ready;
    logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
    logic [1:0] forward_a_e, forward_b_e;
    logic       mem_timeout;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_lw_stall_cnt, perf_flush_cnt, perf_mem_wait_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: INIT cycles left, consecutive frozen cycles, sticky timeout.
    int init_left;
    int stall_run;
    bit sticky;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .INIT_CYCLES (INIT_CYCLES),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .rs1_e        (rs1_e),
        .rs2_e        (rs2_e),
        .rd_e         (rd_e),
        .rd_m         (rd_m),
        .rd_w         (rd_w),
        .regwrite_m   (regwrite_m),
        .regwrite_w   (regwrite_w),
        .resultsrc_e0 (resultsrc_e0),
        .pcsrc_e      (pcsrc_e),
        .memaccess_m  (memaccess_m),
        .dmem_ready   (dmem_ready),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .stall_e      (stall_e),
        .stall_m      (stall_m),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .flush_w      (flush_w),
        .forward_a_e  (forward_a_e),
        .forward_b_e  (forward_b_e),
        .mem_timeout  (mem_timeout)
`ifdef HAZ_PERF_CNT_EN
        ,
        .perf_lw_stall_cnt (perf_lw_stall_cnt),
        .perf_flush_cnt    (perf_flush_cnt),
        .perf_mem_wait_cnt (perf_mem_wait_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [1:0] fwd_model(input logic [4:0] rs, input logic [4:0] rdm,
                                             input logic [4:0] rdw, input logic wm,
                                             input logic ww);
        if (wm && rdm != 0 && rs == rdm) return 2'b10;
        if (ww && rdw != 0 && rs == rdw) return 2'b01;
        return 2'b00;
    endfunction

    task automatic reset_model();
        init_left = INIT_CYCLES;
        stall_run = 0;
        sticky    = 0;
    endtask

    task automatic set_idle();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        regwrite_m = 0; regwrite_w = 0; resultsrc_e0 = 0; pcsrc_e = 0;
        memaccess_m = 0; dmem_ready = 1;
    endtask

    // Checks one cycle at the falling edge, then advances the model at the rising edge.
    task automatic cycle();
        logic [6:0] exp_ctl;
        logic [1:0] ea, eb;
        bit         pend, to, ms, lw;
        @(negedge clk);
        pend = memaccess_m && !dmem_ready;
        to   = pend && (stall_run == int'(MEM_TIMEOUT) - 1);
        ms   = pend && !to;
        lw   = resultsrc_e0 && rd_e != 0 && (rs1_d == rd_e || rs2_d == rd_e);
        ea   = 2'b00;
        eb   = 2'b00;
        if (!rst_n || init_left > 0) begin
            exp_ctl = 7'b1000111;
        end else begin
            ea = fwd_model(rs1_e, rd_m, rd_w, regwrite_m, regwrite_w);
            eb = fwd_model(rs2_e, rd_m, rd_w, regwrite_m, regwrite_w);
            if (ms)           exp_ctl = 7'b1111001;
            else if (pcsrc_e) exp_ctl = 7'b0000110;
            else if (lw)      exp_ctl = 7'b1100010;
            else              exp_ctl = 7'b0000000;
        end
        check_eq("ctl{sf,sd,se,sm,fd,fe,fw}",
                 32'({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}),
                 32'(exp_ctl));
        check_eq("forward_a_e", 32'(forward_a_e), 32'(ea));
        check_eq("forward_b_e", 32'(forward_b_e), 32'(eb));
        check_eq("mem_timeout", 32'(mem_timeout), 32'(sticky));
        @(posedge clk);
        if (!rst_n) begin
            reset_model();
        end else if (init_left > 0) begin
            init_left--;
        end else begin
            if (to) sticky = 1;
            stall_run = ms ? stall_run + 1 : 0;
        end
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_idle();
        rst_n = 0;
        reset_model();
        repeat (2) cycle();
        rst_n = 1;
        repeat (4) cycle();

        // Forwarding: M beats W; zero register never forwards.
        rd_m = 5; regwrite_m = 1; rd_w = 5; regwrite_w = 1; rs1_e = 5; rs2_e = 0;
        cycle();
        check_eq("fwd_a_m_priority", 32'(forward_a_e), 32'(2'b10));
        check_eq("fwd_b_none", 32'(forward_b_e), 32'(2'b00));
        rd_m = 0; rd_w = 0;
        cycle();
        check_eq("fwd_a_x0", 32'(forward_a_e), 32'(2'b00));
        set_idle();

        // Load-use, then load-use masked by a taken branch.
        resultsrc_e0 = 1; rd_e = 7; rs2_d = 7;
        cycle();
        pcsrc_e = 1;
        cycle();
        set_idle();
        cycle();

        // Short memory wait with a branch during the freeze.
        memaccess_m = 1; dmem_ready = 0;
        cycle();
        pcsrc_e = 1;
        repeat (2) cycle();
        dmem_ready = 1;
        cycle();
        set_idle();
        cycle();

        // Memory wait that runs into the timeout.
        memaccess_m = 1; dmem_ready = 0;
        repeat (MEM_TIMEOUT + 1) cycle();
        set_idle();
        cycle();
        check_eq("mem_timeout_sticky", 32'(mem_timeout), 32'd1);
        repeat (2) cycle();

        // Reset in the middle of a wait.
        memaccess_m = 1; dmem_ready = 0;
        repeat (3) cycle();
        rst_n = 0;
        reset_model();
        #1;
        check_eq("mem_timeout_cleared", 32'(mem_timeout), 32'd0);
        cycle();
        set_idle();
        cycle();
        rst_n = 1;
        repeat (4) cycle();

        // Randomized traffic over a small register range so hazards collide often.
        for (int i = 0; i < 800; i++) begin
            rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
            rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
            rd_e  = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
            rd_w  = 5'($urandom_range(0, 3));
            regwrite_m   = 1'($urandom_range(0, 1));
            regwrite_w   = 1'($urandom_range(0, 1));
            resultsrc_e0 = ($urandom_range(0, 2) == 0);
            pcsrc_e      = ($urandom_range(0, 4) == 0);
            memaccess_m  = ($urandom_range(0, 2) == 0);
            dmem_ready   = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 0;
                reset_model();
                cycle();
                rst_n = 1;
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
